// File: rtl/prio_enc_8to3_latched.sv
// Clocked 8-to-3 priority encoder with edge-captured pending requests
// and a VALID/ACK drain handshake. Bit 7 has the highest priority.
module prio_enc_8to3_latched (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EI_L,
  input  logic [7:0] I_L,
  input  logic       ACK,
  output logic [2:0] Y,
  output logic       VALID,
  output logic       GS_L,
  output logic       EO_L,
  output logic       OVF
);

  typedef enum logic {
    IDLE,
    PRES
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] s1_q, s2_q, s3_q;
  logic [7:0] p_q, p_d;
  logic [7:0] edg, clr;
  logic [2:0] y_q, y_d, hi_idx;
  logic       valid_q, valid_d;
  logic       gs_q, gs_d;
  logic       eo_q, eo_d;
  logic       ovf_q, ovf_d;

  // s3 is the history flop: a fall is s3 high while s2 already low
  assign edg = s3_q & ~s2_q;
  assign clr = (state_q == PRES && ACK) ? (8'b1 << y_q) : 8'b0;

  always_comb begin
    p_d   = (p_q & ~clr) | edg;
    ovf_d = |(edg & p_q & ~clr);
    gs_d  = ~|p_d;
    eo_d  = ~(~EI_L & ~|p_d);
  end

  always_comb begin
    hi_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (p_q[i]) hi_idx = 3'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (!EI_L && |p_q) begin
          y_d     = hi_idx;
          valid_d = 1'b1;
          state_d = PRES;
        end
      end
      PRES: begin
        if (ACK) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q    <= 8'hFF;
      s2_q    <= 8'hFF;
      s3_q    <= 8'hFF;
      p_q     <= 8'h00;
      state_q <= IDLE;
      y_q     <= 3'd0;
      valid_q <= 1'b0;
      gs_q    <= 1'b1;
      eo_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= I_L;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      p_q     <= p_d;
      state_q <= state_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      gs_q    <= gs_d;
      eo_q    <= eo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Y     = y_q;
  assign VALID = valid_q;
  assign GS_L  = gs_q;
  assign EO_L  = eo_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_prio_enc_8to3_latched.sv
// Directed bench for prio_enc_8to3_latched: latency, priority,
// no-preempt, overflow/ACK race, enable gating and async reset.
module tb_prio_enc_8to3_latched;

  logic       CLK;
  logic       RST;
  logic       EI_L;
  logic [7:0] I_L;
  logic       ACK;
  logic [2:0] Y;
  logic       VALID;
  logic       GS_L;
  logic       EO_L;
  logic       OVF;

  int checks = 0;
  int errors = 0;

  prio_enc_8to3_latched dut (
    .CLK  (CLK),
    .RST  (RST),
    .EI_L (EI_L),
    .I_L  (I_L),
    .ACK  (ACK),
    .Y    (Y),
    .VALID(VALID),
    .GS_L (GS_L),
    .EO_L (EO_L),
    .OVF  (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // one rising edge passes; returns at the following falling edge
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  task automatic release_lines();
    I_L = 8'hFF;
    tick(3);
  endtask

  task automatic test_reset();
    RST = 1'b1; EI_L = 1'b0; I_L = 8'hFF; ACK = 1'b0;
    tick(2);
    checks++;
    if (Y !== 3'd0) begin
      errors++; $display("FAIL rst_y got %0d exp 0", Y);
    end
    checks++;
    if (VALID !== 1'b0 || OVF !== 1'b0) begin
      errors++; $display("FAIL rst_valid_ovf got %b%b exp 00", VALID, OVF);
    end
    checks++;
    if (GS_L !== 1'b1 || EO_L !== 1'b1) begin
      errors++; $display("FAIL rst_gs_eo got %b%b exp 11", GS_L, EO_L);
    end
    RST = 1'b0;
    tick();
    checks++;
    if (EO_L !== 1'b0 || GS_L !== 1'b1) begin
      errors++; $display("FAIL rst_eo_after got eo=%b gs=%b exp 0 1", EO_L, GS_L);
    end
  endtask

  task automatic test_single();
    I_L = 8'hDF;
    tick(3);
    checks++;
    if (VALID !== 1'b0) begin
      errors++; $display("FAIL single_early got %b exp 0", VALID);
    end
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd5) begin
      errors++; $display("FAIL single_pres got v=%b y=%0d exp 1 5", VALID, Y);
    end
    checks++;
    if (GS_L !== 1'b0 || EO_L !== 1'b1) begin
      errors++; $display("FAIL single_gs got gs=%b eo=%b exp 0 1", GS_L, EO_L);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b1) begin
      errors++; $display("FAIL single_ack got v=%b gs=%b exp 0 1", VALID, GS_L);
    end
    release_lines();
  endtask

  task automatic test_priority();
    I_L = 8'hBB;
    tick(4);
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd6) begin
      errors++; $display("FAIL prio_first got v=%b y=%0d exp 1 6", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b0) begin
      errors++; $display("FAIL prio_gap got v=%b gs=%b exp 0 0", VALID, GS_L);
    end
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd2) begin
      errors++; $display("FAIL prio_second got v=%b y=%0d exp 1 2", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b1) begin
      errors++; $display("FAIL prio_done got v=%b gs=%b exp 0 1", VALID, GS_L);
    end
    release_lines();
  endtask

  task automatic test_no_preempt();
    I_L = 8'hFD;
    tick(4);
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd1) begin
      errors++; $display("FAIL nopre_first got v=%b y=%0d exp 1 1", VALID, Y);
    end
    I_L = 8'h7D;
    tick(5);
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd1) begin
      errors++; $display("FAIL nopre_hold got v=%b y=%0d exp 1 1", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd7) begin
      errors++; $display("FAIL nopre_next got v=%b y=%0d exp 1 7", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    release_lines();
  endtask

  task automatic test_overflow();
    I_L = 8'hF7;
    tick(4);
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd3) begin
      errors++; $display("FAIL ovf_pres got v=%b y=%0d exp 1 3", VALID, Y);
    end
    release_lines();
    I_L = 8'hF7;
    tick(3);
    checks++;
    if (OVF !== 1'b1) begin
      errors++; $display("FAIL ovf_pulse got %b exp 1", OVF);
    end
    tick();
    checks++;
    if (OVF !== 1'b0) begin
      errors++; $display("FAIL ovf_width got %b exp 0", OVF);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick(2);
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b1) begin
      errors++; $display("FAIL ovf_single got v=%b gs=%b exp 0 1", VALID, GS_L);
    end
    release_lines();
  endtask

  task automatic test_ack_race();
    I_L = 8'hF7;
    tick(4);
    release_lines();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd3) begin
      errors++; $display("FAIL race_pres got v=%b y=%0d exp 1 3", VALID, Y);
    end
    I_L = 8'hF7;
    tick(2);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    checks++;
    if (OVF !== 1'b0 || VALID !== 1'b0 || GS_L !== 1'b0) begin
      errors++;
      $display("FAIL race_ack got ovf=%b v=%b gs=%b exp 0 0 0", OVF, VALID, GS_L);
    end
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd3) begin
      errors++; $display("FAIL race_reserve got v=%b y=%0d exp 1 3", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    release_lines();
  endtask

  task automatic test_enable_reset();
    EI_L = 1'b1;
    I_L  = 8'hEF;
    tick(4);
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b0 || EO_L !== 1'b1) begin
      errors++;
      $display("FAIL en_block got v=%b gs=%b eo=%b exp 0 0 1", VALID, GS_L, EO_L);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick();
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b0) begin
      errors++; $display("FAIL en_stray_ack got v=%b gs=%b exp 0 0", VALID, GS_L);
    end
    EI_L = 1'b0;
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd4) begin
      errors++; $display("FAIL en_launch got v=%b y=%0d exp 1 4", VALID, Y);
    end
    #2 RST = 1'b1;
    #1;
    checks++;
    if (VALID !== 1'b0 || Y !== 3'd0 || GS_L !== 1'b1 ||
        EO_L !== 1'b1 || OVF !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got v=%b y=%0d gs=%b eo=%b ovf=%b exp 0 0 1 1 0",
               VALID, Y, GS_L, EO_L, OVF);
    end
    tick();
    RST = 1'b0;
    tick(3);
    checks++;
    if (VALID !== 1'b0) begin
      errors++; $display("FAIL held_early got %b exp 0", VALID);
    end
    tick();
    checks++;
    if (VALID !== 1'b1 || Y !== 3'd4) begin
      errors++; $display("FAIL held_event got v=%b y=%0d exp 1 4", VALID, Y);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    tick(4);
    checks++;
    if (VALID !== 1'b0 || GS_L !== 1'b1) begin
      errors++; $display("FAIL held_once got v=%b gs=%b exp 0 1", VALID, GS_L);
    end
    release_lines();
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_overflow();
    test_ack_race();
    test_enable_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
